// File: rtl/sync_debounce_pkg.sv
// Shared defaults and types for the parametrised input synchronizer/debouncer.
package sync_debounce_pkg;

  localparam int DEF_WIDTH           = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 16;

  // Debounce counter at the default width
  typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage : sync_debounce_pkg

// File: rtl/sync_debounce_channel.sv
// One input channel: synchronizer chain, debounce counter, level and strobe registers.
module debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   synced;
  logic                   differs;
  logic                   flip;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign differs = (synced != out);
  // The level flips on the edge the counter would otherwise reach DEBOUNCE_CYCLES,
  // so the counter can never saturate or wrap.
  assign flip    = differs && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      if (!differs || flip) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flip) begin
        out <= synced;
      end
      rise <= flip & synced;
      fall <= flip & ~synced;
    end
  end

endmodule : debounce_channel

// File: rtl/sync_debounce.sv
// Parametrised multi-channel synchronizer + debouncer with rise/fall strobes.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("sync_debounce: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_deb
    $error("sync_debounce: DEBOUNCE_CYCLES=%0d outside 1..2^CNT_W-1", DEBOUNCE_CYCLES);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .in   (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign changed = |(rise | fall);

endmodule : sync_debounce
